uart_rx_buffered: RTL and testbench
===================================

Name: uart_rx_buffered

Overview:
Parametrised successor to uart_port's receive path. It generates its own oversampling tick from clk, so no separate uart_clk is needed. Data width, parity mode and line polarity are configurable. Received words, each with per-word error flags, go into a show-ahead FIFO that the CPU/bus side drains with a pop strobe.

Parameters:
CLK_HZ, 22118400, system clock frequency in Hz
BAUD, 115200, line rate in bit/s
OVERSAMPLE, 16, ticks per bit; even, >=8
DATA_BITS, 8, data bits per frame; 5..9
PARITY, 0, parity mode: 0 none, 1 odd, 2 even
RX_INVERT, 0, 1 inverts uart_port_DI before all processing
FIFO_DEPTH, 16, FIFO entries; power of 2, >=2

Ports:
clk  in  1  system clock; all logic on its rising edge
clear  in  1  reset; asynchronous, active-high
uart_port_DI  in  1  serial RX line; idle high after optional inversion
rd_en  in  1  pop strobe; pops the FIFO head this cycle
err_clr  in  1  clears the sticky overrun flag
uart_DO  out  DATA_BITS  FIFO head data; valid while read_valid=1
uart_err  out  2  FIFO head flags: [0] framing error, [1] parity error
read_valid  out  1  FIFO not empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries
overrun  out  1  sticky: a word was dropped because the FIFO was full

Behaviour:
- Reset (clear=1, asynchronous): FSM enters IDLE; tick divider, bit counters and FIFO pointers cleared.
  - Outputs after reset: uart_DO=0, uart_err=0, read_valid=0, fifo_count=0, overrun=0.
  - Synchroniser flops reset to 1 (idle line level).
  - A frame in progress is discarded.
- Line input: uart_port_DI passes through a 2-flop synchroniser, then is XORed with RX_INVERT.
- Tick generation: DIV = round(CLK_HZ/(BAUD*OVERSAMPLE)), computed at elaboration (12 at defaults). One-cycle tick pulse every DIV clocks. The divider restarts at the start-edge detect so bit-centre alignment is exact.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: a synchronised 1->0 transition enters START with the tick counter at 0.
  - START: at OVERSAMPLE/2 ticks, sample the line. Sample 0 -> DATA. Sample 1 is a false start -> IDLE, nothing pushed.
  - DATA: sample every OVERSAMPLE ticks after the start-bit centre, LSB first, DATA_BITS samples. Then go to PARITY if PARITY!=0, else STOP.
  - PARITY: sample one bit. Parity error if the XOR of data bits and parity bit is 1 for even, or 0 for odd.
  - STOP: sample one bit. Sample 0 sets the framing error flag.
  - Push: on the STOP sample cycle, push {perr, ferr, data}. Then go to IDLE if the stop bit was 1, else BREAK.
  - BREAK: wait for a synchronised 1, then IDLE. A break (all zeros) yields exactly one word with ferr=1.
- Latency: push occurs (1 + DATA_BITS + (PARITY!=0) + 0.5) bit times after the synchronised start edge, ±1 tick. read_valid rises the clock after the push.
- FIFO behaviour:
  - Show-ahead: uart_DO/uart_err present the head combinationally from registered storage.
  - Pointers wrap modulo FIFO_DEPTH.
  - rd_en with read_valid=0 is ignored.
  - Push while full with no rd_en in the same cycle: word dropped, overrun set, FIFO unchanged.
  - Push while full with rd_en in the same cycle: both occur, count unchanged, no overrun.
  - Push and pop on a non-empty FIFO in the same cycle: count unchanged.
  - Push into an empty FIFO: read_valid=1 next cycle.
- overrun is cleared only by err_clr or clear. If err_clr and a new overrun event occur in the same cycle, overrun stays set.

Test Plan:
1. Defaults, 8N1 frame 0x41 at 115200 (8.68us/bit) -> read_valid rises ~82.5us after start edge; uart_DO=0x41, uart_err=00, fifo_count=1; one rd_en pulse -> read_valid=0, fifo_count=0.
2. Line low for 4 ticks (48 clk), then high -> no push, fifo_count=0, FSM back in IDLE; a following 0x5A frame received correctly.
3. Frame 0x55 with stop bit 0, line held low 3 bit times -> one word, uart_DO=0x55, uart_err[0]=1; after the line returns high for 1 bit, frame 0x42 gives uart_err=00.
4. PARITY=2, frame 0x03 with parity bit 1 -> uart_err[1]=1; same frame with parity bit 0 -> uart_err=00. PARITY=1, frame 0x03 with parity bit 1 -> uart_err=00.
5. FIFO_DEPTH=4: send 0x41..0x45 without reads -> fifo_count=4, overrun=1; reads return 0x41,0x42,0x43,0x44; err_clr -> overrun=0. Repeat with rd_en asserted on the 5th push cycle -> no overrun.
6. clear asserted during data bit 3 -> all outputs zero immediately (asynchronous). Next frame 0x41 received correctly. RX_INVERT=1 with inverted stimulus for 0x41 -> uart_DO=0x41.

Source files
------------

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: oversampling UART receiver with a show-ahead receive FIFO.
// The bit-rate tick is derived internally from clk. Each received word is stored
// together with its framing and parity error flags.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   clear        asynchronous active-high reset
//   uart_port_DI serial RX line (idle high after optional inversion)
//   rd_en        pop strobe for the FIFO head
//   err_clr      clears the sticky overrun flag
//   uart_DO      FIFO head data (zero while the FIFO is empty)
//   uart_err     FIFO head flags: [0] framing error, [1] parity error
//   read_valid   FIFO not empty
//   fifo_count   number of occupied FIFO entries
//   overrun      sticky: a word was dropped because the FIFO was full
module uart_rx_buffered #(
    parameter int CLK_HZ     = 22118400,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int RX_INVERT  = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          clear,
    input  logic                          uart_port_DI,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [DATA_BITS-1:0]          uart_DO,
    output logic [1:0]                    uart_err,
    output logic                          read_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun
);

    localparam int DIV     = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W    = $clog2(OVERSAMPLE);
    localparam int BIT_W   = $clog2(DATA_BITS);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = AW + 1;
    localparam int ENTRY_W = DATA_BITS + 2;
    localparam logic INV   = (RX_INVERT != 0);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t state, state_next;

    logic             sync1, sync2, rx, rx_prev;
    logic [DIV_W-1:0] div_cnt;
    logic [OS_W-1:0]  tick_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic             par_bit;
    logic             tick, start_edge, sample_pt, push;
    logic             perr, ferr;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [ENTRY_W-1:0] head;
    logic               full, do_push, do_pop, ovr_set;

    // Line synchroniser; flops reset to the idle level.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= uart_port_DI;
            sync2   <= sync1;
            rx_prev <= rx;
        end
    end

    assign rx         = sync2 ^ INV;
    assign tick       = (div_cnt == DIV_W'(DIV - 1));
    assign start_edge = (state == S_IDLE) && rx_prev && !rx;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) state <= S_IDLE;
        else       state <= state_next;
    end

    // The start bit is sampled after half a bit; every later bit a full bit
    // further on, so all samples land on bit centres.
    always_comb begin
        state_next = state;
        sample_pt  = 1'b0;
        if (tick) begin
            case (state)
                S_START:                 sample_pt = (tick_cnt == OS_W'(OVERSAMPLE / 2 - 1));
                S_DATA, S_PARITY, S_STOP: sample_pt = (tick_cnt == OS_W'(OVERSAMPLE - 1));
                default:                 sample_pt = 1'b0;
            endcase
        end
        case (state)
            S_IDLE:   if (start_edge) state_next = S_START;
            S_START:  if (sample_pt) state_next = rx ? S_IDLE : S_DATA;
            S_DATA:   if (sample_pt && bit_cnt == BIT_W'(DATA_BITS - 1))
                          state_next = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (sample_pt) state_next = S_STOP;
            S_STOP:   if (sample_pt) state_next = rx ? S_IDLE : S_BREAK;
            S_BREAK:  if (rx) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    assign push = (state == S_STOP) && sample_pt;
    assign ferr = ~rx;
    assign perr = (PARITY == 2) ? (^shreg ^ par_bit) :
                  (PARITY == 1) ? ~(^shreg ^ par_bit) : 1'b0;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
        end else begin
            if (start_edge) begin
                div_cnt  <= '0;
                tick_cnt <= '0;
                bit_cnt  <= '0;
            end else begin
                div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
                if (tick) tick_cnt <= sample_pt ? '0 : tick_cnt + OS_W'(1);
            end
            if (sample_pt && state == S_DATA) begin
                shreg   <= {rx, shreg[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
            if (sample_pt && state == S_PARITY) par_bit <= rx;
        end
    end

    // FIFO
    assign read_valid = (fifo_count != '0);
    assign full       = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign do_pop     = rd_en && read_valid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push    = push && (!full || do_pop);
    assign ovr_set    = push && full && !do_pop;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {perr, ferr, shreg};
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overrun    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (ovr_set)      overrun <= 1'b1;
            else if (err_clr) overrun <= 1'b0;
        end
    end

    assign head     = mem[rd_ptr];
    assign uart_DO  = read_valid ? head[DATA_BITS-1:0] : '0;
    assign uart_err = read_valid ? head[ENTRY_W-1:DATA_BITS] : '0;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Testbench for uart_rx_buffered. Instances: 0 defaults, 1 even parity,
// 2 odd parity, 3 four-entry FIFO, 4 inverted line.
module tb_uart_rx_buffered;

    localparam int BIT_CLK = 192;  // 12 clk per tick * 16 ticks per bit

    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    logic       line [5];
    logic       rd   [5];
    logic       ec   [5];
    logic [7:0] dout [5];
    logic [1:0] err  [5];
    logic       rv   [5];
    logic       ovr  [5];
    logic [4:0] c0, c1, c2, c4;
    logic [2:0] c3;

    int checks   = 0;
    int failures = 0;
    logic [9:0] exp_q [$];

    uart_rx_buffered u_def (
        .clk(clk), .clear(clear), .uart_port_DI(line[0]), .rd_en(rd[0]), .err_clr(ec[0]),
        .uart_DO(dout[0]), .uart_err(err[0]), .read_valid(rv[0]), .fifo_count(c0), .overrun(ovr[0]));
    uart_rx_buffered #(.PARITY(2)) u_even (
        .clk(clk), .clear(clear), .uart_port_DI(line[1]), .rd_en(rd[1]), .err_clr(ec[1]),
        .uart_DO(dout[1]), .uart_err(err[1]), .read_valid(rv[1]), .fifo_count(c1), .overrun(ovr[1]));
    uart_rx_buffered #(.PARITY(1)) u_odd (
        .clk(clk), .clear(clear), .uart_port_DI(line[2]), .rd_en(rd[2]), .err_clr(ec[2]),
        .uart_DO(dout[2]), .uart_err(err[2]), .read_valid(rv[2]), .fifo_count(c2), .overrun(ovr[2]));
    uart_rx_buffered #(.FIFO_DEPTH(4)) u_d4 (
        .clk(clk), .clear(clear), .uart_port_DI(line[3]), .rd_en(rd[3]), .err_clr(ec[3]),
        .uart_DO(dout[3]), .uart_err(err[3]), .read_valid(rv[3]), .fifo_count(c3), .overrun(ovr[3]));
    uart_rx_buffered #(.RX_INVERT(1)) u_inv (
        .clk(clk), .clear(clear), .uart_port_DI(line[4]), .rd_en(rd[4]), .err_clr(ec[4]),
        .uart_DO(dout[4]), .uart_err(err[4]), .read_valid(rv[4]), .fifo_count(c4), .overrun(ovr[4]));

    function automatic logic [4:0] fcnt(input int idx);
        case (idx)
            0:       return c0;
            1:       return c1;
            2:       return c2;
            3:       return {2'b00, c3};
            default: return c4;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drives one frame, LSB first; must be called at a negedge. The line is
    // left at the stop-bit level.
    task automatic send_frame(input int idx, input logic [7:0] data, input bit has_par,
                              input logic par_bit, input logic stop_bit, input logic inv);
        logic [10:0] v;
        int n;
        v = '1;
        v[0] = 1'b0;
        v[8:1] = data;
        if (has_par) begin
            v[9] = par_bit; v[10] = stop_bit; n = 11;
        end else begin
            v[9] = stop_bit; n = 10;
        end
        for (int i = 0; i < n; i++) begin
            line[idx] = v[i] ^ inv;
            repeat (BIT_CLK) @(negedge clk);
        end
    endtask

    task automatic expect_word(input int idx, input string tag);
        int w;
        logic [9:0] e;
        w = 0;
        while (!rv[idx] && w < 3000) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_valid"}, 32'(rv[idx]), 32'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h3ff;
        check(tag, {22'd0, err[idx], dout[idx]}, {22'd0, e});
        rd[idx] = 1'b1;
        @(negedge clk);
        rd[idx] = 1'b0;
    endtask

    initial begin
        int w;
        for (int i = 0; i < 5; i++) begin
            line[i] = (i == 4) ? 1'b0 : 1'b1;
            rd[i] = 1'b0;
            ec[i] = 1'b0;
        end
        clear = 1'b1;
        #1;
        check("rst_valid", 32'(rv[0]), 0);
        check("rst_count", 32'(fcnt(0)), 0);
        check("rst_data", 32'(dout[0]), 0);
        check("rst_err", 32'(err[0]), 0);
        check("rst_ovr", 32'(ovr[3]), 0);
        repeat (3) @(negedge clk);
        clear = 1'b0;
        repeat (BIT_CLK) @(negedge clk);

        // 1: basic 8N1 frame and latency
        exp_q.push_back({2'b00, 8'h41});
        w = 0;
        fork
            send_frame(0, 8'h41, 0, 1'b0, 1'b1, 1'b0);
            begin
                while (!rv[0] && w < 3000) begin
                    @(negedge clk);
                    w++;
                end
            end
        join
        check("t1_latency", 32'(w >= 1820 && w <= 1834), 1);
        check("t1_count", 32'(fcnt(0)), 1);
        expect_word(0, "t1_word");
        check("t1_empty", 32'(rv[0]), 0);
        check("t1_count0", 32'(fcnt(0)), 0);

        // 2: false start then a good frame
        line[0] = 1'b0;
        repeat (48) @(negedge clk);
        line[0] = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        check("t2_nopush", 32'(fcnt(0)), 0);
        exp_q.push_back({2'b00, 8'h5A});
        send_frame(0, 8'h5A, 0, 1'b0, 1'b1, 1'b0);
        expect_word(0, "t2_word");

        // 3: break, then recovery
        exp_q.push_back({2'b01, 8'h55});
        send_frame(0, 8'h55, 0, 1'b0, 1'b0, 1'b0);
        repeat (3 * BIT_CLK) @(negedge clk);
        line[0] = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        check("t3_one_word", 32'(fcnt(0)), 1);
        expect_word(0, "t3_break");
        exp_q.push_back({2'b00, 8'h42});
        send_frame(0, 8'h42, 0, 1'b0, 1'b1, 1'b0);
        expect_word(0, "t3_after");

        // 4: parity
        exp_q.push_back({2'b10, 8'h03});
        send_frame(1, 8'h03, 1, 1'b1, 1'b1, 1'b0);
        expect_word(1, "t4_even_bad");
        exp_q.push_back({2'b00, 8'h03});
        send_frame(1, 8'h03, 1, 1'b0, 1'b1, 1'b0);
        expect_word(1, "t4_even_ok");
        exp_q.push_back({2'b00, 8'h03});
        send_frame(2, 8'h03, 1, 1'b1, 1'b1, 1'b0);
        expect_word(2, "t4_odd_ok");
        exp_q.push_back({2'b10, 8'h03});
        send_frame(2, 8'h03, 1, 1'b0, 1'b1, 1'b0);
        expect_word(2, "t4_odd_bad");

        // 5: overrun on a 4-entry FIFO
        for (int d = 8'h41; d <= 8'h45; d++) begin
            if (d != 8'h45) exp_q.push_back({2'b00, 8'(d)});
            send_frame(3, 8'(d), 0, 1'b0, 1'b1, 1'b0);
        end
        check("t5_full", 32'(fcnt(3)), 4);
        check("t5_ovr", 32'(ovr[3]), 1);
        for (int k = 0; k < 4; k++) expect_word(3, "t5_read");
        check("t5_drained", 32'(rv[3]), 0);
        ec[3] = 1'b1;
        @(negedge clk);
        ec[3] = 1'b0;
        check("t5_ovr_clr", 32'(ovr[3]), 0);

        for (int d = 8'h41; d <= 8'h44; d++) begin
            if (d != 8'h41) exp_q.push_back({2'b00, 8'(d)});
            send_frame(3, 8'(d), 0, 1'b0, 1'b1, 1'b0);
        end
        exp_q.push_back({2'b00, 8'h45});
        check("t5_full2", 32'(fcnt(3)), 4);
        fork
            send_frame(3, 8'h45, 0, 1'b0, 1'b1, 1'b0);
            begin
                // push lands on the 1827th rising edge after the start bit
                repeat (1826) @(negedge clk);
                check("t5_head", 32'(dout[3]), 32'h41);
                rd[3] = 1'b1;
                @(negedge clk);
                rd[3] = 1'b0;
                check("t5_same_cnt", 32'(fcnt(3)), 4);
            end
        join
        check("t5_no_ovr", 32'(ovr[3]), 0);
        for (int k = 0; k < 4; k++) expect_word(3, "t5_read2");

        // 6: asynchronous clear mid-frame
        send_frame(0, 8'h41, 0, 1'b0, 1'b1, 1'b0);
        check("t6_pre", 32'(rv[0]), 1);
        fork
            send_frame(0, 8'h41, 0, 1'b0, 1'b1, 1'b0);
            begin
                repeat (4 * BIT_CLK + 96) @(negedge clk);
                #2 clear = 1'b1;
                #1;
                check("t6_valid", 32'(rv[0]), 0);
                check("t6_count", 32'(fcnt(0)), 0);
                check("t6_data", 32'(dout[0]), 0);
                check("t6_err", 32'(err[0]), 0);
            end
        join
        repeat (BIT_CLK) @(negedge clk);
        clear = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        check("t6_idle", 32'(fcnt(0)), 0);
        exp_q.push_back({2'b00, 8'h41});
        send_frame(0, 8'h41, 0, 1'b0, 1'b1, 1'b0);
        expect_word(0, "t6_word");

        // inverted line
        exp_q.push_back({2'b00, 8'h41});
        send_frame(4, 8'h41, 0, 1'b0, 1'b1, 1'b1);
        expect_word(4, "inv_word");
        check("inv_count", 32'(fcnt(4)), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
